// File: rtl/uart_rx_monitor.sv
// uart_rx_monitor
//   UART receiver with an error-tagged receive FIFO.
//   The serial input is double-synchronised. A falling edge starts a frame.
//   Data bits are sampled near mid-bit, LSB first, followed by optional
//   parity and 1 or 2 stop bits. Every frame that ends pushes
//   {frame_err, parity_err, data} into the FIFO. This includes frames with
//   errors and a single break entry.
//
// Ports
//   clk          : clock, rising edge
//   rst_n        : asynchronous active-low reset
//   rx_i         : serial line, idle high, asynchronous to clk
//   data_o       : head-of-FIFO data, LSB-aligned, upper bits zero
//   valid_o      : FIFO non-empty
//   ready_i      : consumer accepts head entry (pop when valid_o & ready_i)
//   frame_err_o  : head entry had a low stop bit
//   parity_err_o : head entry had a parity mismatch
//   overflow_o   : sticky, a frame was dropped because the FIFO was full
//   clear_i      : synchronous clear of overflow_o
//   level_o      : FIFO occupancy, 0..FIFO_DEPTH
module uart_rx_monitor #(
  parameter int unsigned CLKS_PER_BIT = 434,
  parameter int unsigned DATA_BITS    = 8,
  parameter int unsigned PARITY       = 0,
  parameter int unsigned STOP_BITS    = 1,
  parameter int unsigned FIFO_DEPTH   = 8
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          rx_i,
  output logic [7:0]                    data_o,
  output logic                          valid_o,
  input  logic                          ready_i,
  output logic                          frame_err_o,
  output logic                          parity_err_o,
  output logic                          overflow_o,
  input  logic                          clear_i,
  output logic [$clog2(FIFO_DEPTH):0]   level_o
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF_M1   = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL_M1   = CW'(CLKS_PER_BIT - 1);
  localparam logic [3:0]    LAST_DATA = 4'(DATA_BITS - 1);
  localparam logic [3:0]    LAST_STOP = 4'(STOP_BITS - 1);
  localparam logic [AW:0]   DEPTH_L   = (AW+1)'(FIFO_DEPTH);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_START = 3'd1;
  localparam logic [2:0] S_DATA  = 3'd2;
  localparam logic [2:0] S_PAR   = 3'd3;
  localparam logic [2:0] S_STOP  = 3'd4;
  localparam logic [2:0] S_BREAK = 3'd5;

  // Synchroniser plus one history flop for falling-edge detection
  logic rx_meta, rx_sync, rx_prev;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_meta <= rx_i;
      rx_sync <= rx_meta;
      rx_prev <= rx_sync;
    end
  end

  logic [2:0]           state;
  logic [CW-1:0]        clk_cnt;
  logic [3:0]           bit_cnt;
  logic [DATA_BITS-1:0] shreg;
  logic                 frame_err, parity_err;
  logic                 sample;

  assign sample = (clk_cnt == FULL_M1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      clk_cnt    <= '0;
      bit_cnt    <= '0;
      shreg      <= '0;
      frame_err  <= 1'b0;
      parity_err <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (rx_prev && !rx_sync) begin
            state      <= S_START;
            clk_cnt    <= '0;
            bit_cnt    <= '0;
            frame_err  <= 1'b0;
            parity_err <= 1'b0;
          end
        end
        S_START: begin
          if (clk_cnt == HALF_M1) begin
            clk_cnt <= '0;
            state   <= rx_sync ? S_IDLE : S_DATA;
          end else begin
            clk_cnt <= clk_cnt + CW'(1);
          end
        end
        S_DATA: begin
          if (sample) begin
            clk_cnt <= '0;
            shreg   <= {rx_sync, shreg[DATA_BITS-1:1]};
            if (bit_cnt == LAST_DATA) begin
              bit_cnt <= '0;
              state   <= (PARITY != 0) ? S_PAR : S_STOP;
            end else begin
              bit_cnt <= bit_cnt + 4'd1;
            end
          end else begin
            clk_cnt <= clk_cnt + CW'(1);
          end
        end
        S_PAR: begin
          if (sample) begin
            clk_cnt    <= '0;
            parity_err <= (PARITY == 1) ? ~(^shreg ^ rx_sync) : (^shreg ^ rx_sync);
            state      <= S_STOP;
          end else begin
            clk_cnt <= clk_cnt + CW'(1);
          end
        end
        S_STOP: begin
          if (sample) begin
            clk_cnt <= '0;
            if (!rx_sync) frame_err <= 1'b1;
            if (bit_cnt == LAST_STOP) begin
              bit_cnt <= '0;
              state   <= rx_sync ? S_IDLE : S_BREAK;
            end else begin
              bit_cnt <= bit_cnt + 4'd1;
            end
          end else begin
            clk_cnt <= clk_cnt + CW'(1);
          end
        end
        S_BREAK: begin
          if (rx_sync) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // The push happens on the final stop sample. That sample's own value is
  // folded into the frame error here, because the register has not caught
  // up with it yet.
  logic       push;
  logic [7:0] data_ext;
  logic [9:0] push_entry;

  always_comb begin
    data_ext                  = '0;
    data_ext[DATA_BITS-1:0]   = shreg;
    push       = (state == S_STOP) && sample && (bit_cnt == LAST_STOP);
    push_entry = {frame_err | ~rx_sync, parity_err, data_ext};
  end

  // FIFO
  logic [9:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr, rd_n;
  logic [AW:0]   count, count_n;
  logic          pop, push_ok;
  logic [9:0]    head_n;

  always_comb begin
    pop     = valid_o & ready_i;
    push_ok = push & ((count != DEPTH_L) | pop);
    rd_n    = pop ? rd_ptr + AW'(1) : rd_ptr;
    case ({push_ok, pop})
      2'b10:   count_n = count + (AW+1)'(1);
      2'b01:   count_n = count - (AW+1)'(1);
      default: count_n = count;
    endcase
    // When wr_ptr equals the next read pointer and a write succeeds, the
    // FIFO was empty after any pop. The incoming entry therefore becomes
    // the head directly.
    head_n = '0;
    if (count_n != '0) begin
      if (push_ok && (wr_ptr == rd_n)) head_n = push_entry;
      else                             head_n = mem[rd_n];
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= push_entry;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      valid_o      <= 1'b0;
      data_o       <= '0;
      frame_err_o  <= 1'b0;
      parity_err_o <= 1'b0;
      overflow_o   <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      rd_ptr  <= rd_n;
      count   <= count_n;
      valid_o <= (count_n != '0);
      {frame_err_o, parity_err_o, data_o} <= head_n;
      if (push && !push_ok) overflow_o <= 1'b1;
      else if (clear_i)     overflow_o <= 1'b0;
    end
  end

  assign level_o = count;

endmodule

// File: tb/tb_uart_rx_monitor.sv
module tb_uart_rx_monitor;

  localparam int CPB   = 16;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // DUT A: 8N1
  logic       rx_a = 1'b1, ready_a = 1'b0, clear_a = 1'b0;
  logic       rand_on = 1'b0, rand_rdy = 1'b0, ready_a_dut;
  logic [7:0] data_a;
  logic       valid_a, fe_a, pe_a, ovf_a;
  logic [2:0] level_a;
  assign ready_a_dut = rand_on ? rand_rdy : ready_a;

  // DUT P: 8 data, even parity, 2 stop bits
  logic       rx_p = 1'b1, ready_p = 1'b0, clear_p = 1'b0;
  logic [7:0] data_p;
  logic       valid_p, fe_p, pe_p, ovf_p;
  logic [2:0] level_p;

  // DUT B: 5 data bits
  logic       rx_b = 1'b1, ready_b = 1'b0, clear_b = 1'b0;
  logic [7:0] data_b;
  logic       valid_b, fe_b, pe_b, ovf_b;
  logic [2:0] level_b;

  uart_rx_monitor #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(DEPTH)) dut_a (
    .clk(clk), .rst_n(rst_n), .rx_i(rx_a), .data_o(data_a), .valid_o(valid_a), .ready_i(ready_a_dut),
    .frame_err_o(fe_a), .parity_err_o(pe_a), .overflow_o(ovf_a), .clear_i(clear_a), .level_o(level_a));

  uart_rx_monitor #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(2), .STOP_BITS(2), .FIFO_DEPTH(DEPTH)) dut_p (
    .clk(clk), .rst_n(rst_n), .rx_i(rx_p), .data_o(data_p), .valid_o(valid_p), .ready_i(ready_p),
    .frame_err_o(fe_p), .parity_err_o(pe_p), .overflow_o(ovf_p), .clear_i(clear_p), .level_o(level_p));

  uart_rx_monitor #(.CLKS_PER_BIT(CPB), .DATA_BITS(5), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(DEPTH)) dut_b (
    .clk(clk), .rst_n(rst_n), .rx_i(rx_b), .data_o(data_b), .valid_o(valid_b), .ready_i(ready_b),
    .frame_err_o(fe_b), .parity_err_o(pe_b), .overflow_o(ovf_b), .clear_i(clear_b), .level_o(level_b));

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference model for DUT A: a queue of the entries that must come out,
  // in order. While nothing is consumed, the queue size is the occupancy.
  typedef struct packed {logic fe; logic pe; logic [7:0] d;} ent_t;
  ent_t exp_q[$];
  logic exp_ovf = 1'b0;

  typedef struct {
    logic [7:0] data;
    logic       stop;
    logic [7:0] exp_data;
    logic       exp_fe;
  } vec_t;
  vec_t vecs[5];

  always @(posedge clk) begin
    #1 rand_rdy = ($urandom_range(0, 1) != 0);
  end

  // Consumer-side monitor for DUT A
  logic       prev_hold = 1'b0;
  logic [7:0] prev_data = '0;
  always @(negedge clk) begin
    ent_t e;
    if (rst_n) begin
      if (prev_hold && valid_a) check("hold_stable", data_a, prev_data);
      if (valid_a && ready_a_dut) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_pop: got data 0x%0h, expected no entry", data_a);
        end else begin
          e = exp_q.pop_front();
          check("pop_data", data_a, e.d);
          check("pop_frame_err", fe_a, e.fe);
          check("pop_parity_err", pe_a, e.pe);
        end
      end
    end
    prev_hold = valid_a && !ready_a_dut;
    prev_data = data_a;
  end

  task automatic set_line(input int sel, input logic v);
    case (sel)
      0:       rx_a = v;
      1:       rx_p = v;
      default: rx_b = v;
    endcase
  endtask

  // Bits are driven LSB first, each for CPB clocks. The line is left idle afterwards.
  task automatic send_raw(input int sel, input logic [15:0] bits, input int n);
    for (int i = 0; i < n; i++) begin
      set_line(sel, bits[i]);
      repeat (CPB) @(posedge clk);
      #1;
    end
    set_line(sel, 1'b1);
  endtask

  task automatic gap(input int cyc);
    repeat (cyc) @(posedge clk);
    #1;
  endtask

  task automatic send_a(input logic [7:0] d, input logic stop, input ent_t e);
    if (!ready_a && exp_q.size() == DEPTH) exp_ovf = 1'b1;
    else exp_q.push_back(e);
    send_raw(0, {6'h3F, stop, d, 1'b0}, 10);
    gap(2 * CPB);
  endtask

  task automatic drain_a(input int max_cyc, input string name);
    int i = 0;
    while ((exp_q.size() != 0 || valid_a) && i < max_cyc) begin
      @(posedge clk);
      #1;
      i++;
    end
    check(name, exp_q.size(), 0);
  endtask

  task automatic send_p(input logic [7:0] d, input logic par, input logic s2);
    send_raw(1, {4'hF, s2, 1'b1, par, d, 1'b0}, 12);
    gap(2 * CPB);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    ent_t       e;
    logic [7:0] d;
    logic       s;

    vecs[0] = '{8'hA5, 1'b1, 8'hA5, 1'b0};
    vecs[1] = '{8'h00, 1'b1, 8'h00, 1'b0};
    vecs[2] = '{8'hFF, 1'b1, 8'hFF, 1'b0};
    vecs[3] = '{8'h3C, 1'b0, 8'h3C, 1'b1};
    vecs[4] = '{8'h81, 1'b1, 8'h81, 1'b0};

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid", valid_a, 0);
    check("rst_data", data_a, 0);
    check("rst_frame_err", fe_a, 0);
    check("rst_parity_err", pe_a, 0);
    check("rst_overflow", ovf_a, 0);
    check("rst_level", level_a, 0);
    rst_n = 1'b1;
    gap(4);

    // Table-driven frames, consumer always ready
    ready_a = 1'b1;
    for (int i = 0; i < 5; i++) begin
      e.fe = vecs[i].exp_fe;
      e.pe = 1'b0;
      e.d  = vecs[i].exp_data;
      send_a(vecs[i].data, vecs[i].stop, e);
      drain_a(4 * CPB, "vec_drain");
    end

    // False start: 4-cycle low glitch
    rx_a = 1'b0;
    gap(4);
    rx_a = 1'b1;
    gap(3 * CPB);
    check("false_start_level", level_a, 0);
    check("false_start_valid", valid_a, 0);

    // Break: 30 bit times low gives one zero entry with frame error
    e = '{1'b1, 1'b0, 8'h00};
    exp_q.push_back(e);
    rx_a = 1'b0;
    gap(30 * CPB);
    rx_a = 1'b1;
    gap(2 * CPB);
    drain_a(4 * CPB, "break_drain");
    check("break_level", level_a, 0);

    // Overflow: five frames with no consumer
    ready_a = 1'b0;
    for (int k = 0; k < 5; k++) begin
      d = 8'h10 + 8'(k);
      e = '{1'b0, 1'b0, d};
      send_a(d, 1'b1, e);
    end
    check("ovf_level", level_a, DEPTH);
    check("ovf_flag", ovf_a, exp_ovf);
    check("ovf_valid", valid_a, 1);
    check("ovf_head", data_a, 8'h10);
    ready_a = 1'b1;
    drain_a(20, "ovf_drain");
    check("ovf_sticky", ovf_a, 1);
    check("ovf_level_empty", level_a, 0);
    clear_a = 1'b1;
    gap(1);
    clear_a = 1'b0;
    exp_ovf = 1'b0;
    check("ovf_cleared", ovf_a, exp_ovf);

    // Random frames against the model, with random consumer back-pressure
    rand_on = 1'b1;
    for (int k = 0; k < 8; k++) begin
      d = 8'($urandom);
      s = ($urandom_range(0, 4) != 0);
      e = '{~s, 1'b0, d};
      send_a(d, s, e);
    end
    rand_on = 1'b0;
    drain_a(8 * CPB, "rand_drain");
    check("rand_no_ovf", ovf_a, exp_ovf);

    // Even parity, two stop bits
    send_p(8'h03, 1'b1, 1'b1);
    check("par_valid", valid_p, 1);
    check("par_data", data_p, 8'h03);
    check("par_err_set", pe_p, 1);
    check("par_fe", fe_p, 0);
    ready_p = 1'b1;
    gap(1);
    ready_p = 1'b0;
    gap(2);
    check("par_level_pop", level_p, 0);
    send_p(8'h03, 1'b0, 1'b1);
    check("par_ok_data", data_p, 8'h03);
    check("par_err_clear", pe_p, 0);
    send_p(8'h80, 1'b0, 1'b0);
    check("par_level_two", level_p, 2);
    ready_p = 1'b1;
    gap(1);
    ready_p = 1'b0;
    gap(2);
    check("par_second_data", data_p, 8'h80);
    check("par_second_pe", pe_p, 1);
    check("par_second_stop_fe", fe_p, 1);
    ready_p = 1'b1;
    gap(1);
    ready_p = 1'b0;
    gap(2);
    check("par_final_level", level_p, 0);

    // Five data bits
    send_raw(2, {10'h3FF, 5'h1F, 1'b0}, 7);
    gap(2 * CPB);
    check("db5_valid", valid_b, 1);
    check("db5_data", data_b, 8'h1F);
    check("db5_errs", {fe_b, pe_b}, 0);
    ready_b = 1'b1;
    gap(1);
    ready_b = 1'b0;
    send_raw(2, {10'h3FF, 5'h0A, 1'b0}, 7);
    gap(2 * CPB);
    check("db5_data2", data_b, 8'h0A);
    check("db5_level", level_b, 1);
    ready_b = 1'b1;
    gap(1);
    ready_b = 1'b0;
    gap(2);
    check("db5_level_empty", level_b, 0);

    // Reset during the third data bit, with an entry held beforehand
    ready_a = 1'b0;
    send_raw(0, {6'h3F, 1'b1, 8'h77, 1'b0}, 10);
    gap(2 * CPB);
    check("pre_rst_valid", valid_a, 1);
    send_raw(0, {13'h0, 2'b10, 1'b0}, 3);
    rx_a = 1'b0;
    gap(CPB / 2);
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", valid_a, 0);
    check("mid_rst_data", data_a, 0);
    check("mid_rst_level", level_a, 0);
    check("mid_rst_errs", {fe_a, pe_a, ovf_a}, 0);
    rx_a = 1'b1;
    gap(3);
    rst_n = 1'b1;
    gap(2 * CPB);
    check("post_rst_idle", level_a, 0);
    ready_a = 1'b1;
    e = '{1'b0, 1'b0, 8'h5A};
    send_a(8'h5A, 1'b1, e);
    drain_a(4 * CPB, "post_rst_drain");

    check("end_ovf_p", ovf_p, 0);
    check("end_ovf_b", ovf_b, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
